// File: rtl/dbchecker_ctrl_master.sv
// dbchecker_ctrl_master
// AXI4-Lite initiator for the DBChecker control register port. It accepts one
// read or write on a simple valid/ready command interface, runs it as a single
// AXI-Lite beat, and returns the response code, read data and a saturating
// latency count on a valid/ready response interface.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   cmd_*               command request (write flag, address, data, strobes)
//   rsp_*               response (write echo, read data, resp code, latency)
//   m_axil_ctrl_*       AXI4-Lite master channels AW, W, B, AR, R
//
// All handshake outputs are registered; they are computed from the next state
// so that AW/W or AR valid appears on the cycle right after command accept.
module dbchecker_ctrl_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT_W  = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic [LAT_W-1:0]    rsp_latency,
  output logic [ADDR_W-1:0]   m_axil_ctrl_awaddr,
  output logic [2:0]          m_axil_ctrl_awprot,
  output logic                m_axil_ctrl_awvalid,
  input  logic                m_axil_ctrl_awready,
  output logic [DATA_W-1:0]   m_axil_ctrl_wdata,
  output logic [DATA_W/8-1:0] m_axil_ctrl_wstrb,
  output logic                m_axil_ctrl_wvalid,
  input  logic                m_axil_ctrl_wready,
  input  logic [1:0]          m_axil_ctrl_bresp,
  input  logic                m_axil_ctrl_bvalid,
  output logic                m_axil_ctrl_bready,
  output logic [ADDR_W-1:0]   m_axil_ctrl_araddr,
  output logic [2:0]          m_axil_ctrl_arprot,
  output logic                m_axil_ctrl_arvalid,
  input  logic                m_axil_ctrl_arready,
  input  logic [DATA_W-1:0]   m_axil_ctrl_rdata,
  input  logic [1:0]          m_axil_ctrl_rresp,
  input  logic                m_axil_ctrl_rvalid,
  output logic                m_axil_ctrl_rready
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, WR, WB, RA, RR, RSP} state_t;

  state_t              state, state_d;
  logic                aw_done, aw_done_d;
  logic                w_done, w_done_d;
  logic                accept, b_hs, r_hs;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                write_q;
  logic [LAT_W-1:0]    lat_cnt;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign m_axil_ctrl_awaddr = addr_q;
  assign m_axil_ctrl_araddr = addr_q;
  assign m_axil_ctrl_awprot = 3'b000;
  assign m_axil_ctrl_arprot = 3'b000;
  assign m_axil_ctrl_wdata  = wdata_q;
  assign m_axil_ctrl_wstrb  = wstrb_q;

  always_comb begin
    state_d   = state;
    aw_done_d = aw_done;
    w_done_d  = w_done;
    accept    = 1'b0;
    b_hs      = 1'b0;
    r_hs      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept    = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? WR : RA;
        end
      end
      WR: begin
        // AW and W complete independently; leave only once both are done.
        if (m_axil_ctrl_awvalid && m_axil_ctrl_awready) aw_done_d = 1'b1;
        if (m_axil_ctrl_wvalid && m_axil_ctrl_wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = WB;
      end
      WB: begin
        if (m_axil_ctrl_bvalid) begin
          b_hs    = 1'b1;
          state_d = RSP;
        end
      end
      RA: begin
        if (m_axil_ctrl_arready) state_d = RR;
      end
      RR: begin
        if (m_axil_ctrl_rvalid) begin
          r_hs    = 1'b1;
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      aw_done             <= 1'b0;
      w_done              <= 1'b0;
      cmd_ready           <= 1'b0;
      m_axil_ctrl_awvalid <= 1'b0;
      m_axil_ctrl_wvalid  <= 1'b0;
      m_axil_ctrl_arvalid <= 1'b0;
      m_axil_ctrl_bready  <= 1'b0;
      m_axil_ctrl_rready  <= 1'b0;
      rsp_valid           <= 1'b0;
      addr_q              <= '0;
      wdata_q             <= '0;
      wstrb_q             <= '0;
      write_q             <= 1'b0;
      lat_cnt             <= '0;
      rsp_write           <= 1'b0;
      rsp_rdata           <= '0;
      rsp_resp            <= 2'b00;
      rsp_latency         <= '0;
    end else begin
      state               <= state_d;
      aw_done             <= aw_done_d;
      w_done              <= w_done_d;
      cmd_ready           <= (state_d == IDLE);
      m_axil_ctrl_awvalid <= (state_d == WR) && !aw_done_d;
      m_axil_ctrl_wvalid  <= (state_d == WR) && !w_done_d;
      m_axil_ctrl_arvalid <= (state_d == RA);
      m_axil_ctrl_bready  <= (state_d == WB);
      m_axil_ctrl_rready  <= (state_d == RR);
      rsp_valid           <= (state_d == RSP);

      if (accept) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        write_q <= cmd_write;
        lat_cnt <= '0;
      end else if (state == WR || state == WB || state == RA || state == RR) begin
        lat_cnt <= sat_inc(lat_cnt);
      end

      // Latched latency includes the B/R handshake cycle itself.
      if (b_hs || r_hs) begin
        rsp_write   <= write_q;
        rsp_latency <= sat_inc(lat_cnt);
        rsp_resp    <= b_hs ? m_axil_ctrl_bresp : m_axil_ctrl_rresp;
        rsp_rdata   <= b_hs ? '0 : m_axil_ctrl_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dbchecker_ctrl_master.sv
// Directed testbench for dbchecker_ctrl_master. Instance u_dut uses default
// widths behind a configurable-delay AXI-Lite slave model; instance u_sat uses
// LAT_W=4 to exercise latency saturation.
module tb_dbchecker_ctrl_master;

  logic        clock;
  logic        reset;

  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] rsp_latency;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  logic        s_cmd_valid, s_cmd_ready, s_cmd_write;
  logic [31:0] s_cmd_addr, s_cmd_wdata;
  logic [3:0]  s_cmd_wstrb;
  logic        s_rsp_valid, s_rsp_ready, s_rsp_write;
  logic [31:0] s_rsp_rdata;
  logic [1:0]  s_rsp_resp;
  logic [3:0]  s_rsp_latency;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [2:0]  s_awprot, s_arprot;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;

  // slave model configuration and state for u_dut
  int          aw_dly, w_dly, ar_dly;
  int          aw_cnt, w_cnt, ar_cnt, s_ar_cnt;
  logic        aw_seen, w_seen, b_pend, r_pend, s_r_pend;
  logic        w_hold, w_unstable;
  logic [31:0] wdata_prev;
  int          b_count;
  logic [1:0]  bresp_cfg, rresp_cfg;
  logic [31:0] rdata_cfg;

  int n_checks = 0;
  int n_fail   = 0;

  dbchecker_ctrl_master u_dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_latency(rsp_latency),
    .m_axil_ctrl_awaddr(awaddr), .m_axil_ctrl_awprot(awprot),
    .m_axil_ctrl_awvalid(awvalid), .m_axil_ctrl_awready(awready),
    .m_axil_ctrl_wdata(wdata), .m_axil_ctrl_wstrb(wstrb),
    .m_axil_ctrl_wvalid(wvalid), .m_axil_ctrl_wready(wready),
    .m_axil_ctrl_bresp(bresp), .m_axil_ctrl_bvalid(bvalid), .m_axil_ctrl_bready(bready),
    .m_axil_ctrl_araddr(araddr), .m_axil_ctrl_arprot(arprot),
    .m_axil_ctrl_arvalid(arvalid), .m_axil_ctrl_arready(arready),
    .m_axil_ctrl_rdata(rdata), .m_axil_ctrl_rresp(rresp),
    .m_axil_ctrl_rvalid(rvalid), .m_axil_ctrl_rready(rready)
  );

  dbchecker_ctrl_master #(.LAT_W(4)) u_sat (
    .clock(clock), .reset(reset),
    .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_write(s_cmd_write),
    .cmd_addr(s_cmd_addr), .cmd_wdata(s_cmd_wdata), .cmd_wstrb(s_cmd_wstrb),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_write(s_rsp_write),
    .rsp_rdata(s_rsp_rdata), .rsp_resp(s_rsp_resp), .rsp_latency(s_rsp_latency),
    .m_axil_ctrl_awaddr(s_awaddr), .m_axil_ctrl_awprot(s_awprot),
    .m_axil_ctrl_awvalid(s_awvalid), .m_axil_ctrl_awready(1'b1),
    .m_axil_ctrl_wdata(s_wdata), .m_axil_ctrl_wstrb(s_wstrb),
    .m_axil_ctrl_wvalid(s_wvalid), .m_axil_ctrl_wready(1'b1),
    .m_axil_ctrl_bresp(2'b00), .m_axil_ctrl_bvalid(1'b0), .m_axil_ctrl_bready(s_bready),
    .m_axil_ctrl_araddr(s_araddr), .m_axil_ctrl_arprot(s_arprot),
    .m_axil_ctrl_arvalid(s_arvalid), .m_axil_ctrl_arready(s_arready),
    .m_axil_ctrl_rdata(32'hA5A5_A5A5), .m_axil_ctrl_rresp(2'b00),
    .m_axil_ctrl_rvalid(s_rvalid), .m_axil_ctrl_rready(s_rready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slave: each ready rises after the channel's valid has waited *_dly cycles.
  assign awready   = awvalid && (aw_cnt >= aw_dly);
  assign wready    = wvalid && (w_cnt >= w_dly);
  assign arready   = arvalid && (ar_cnt >= ar_dly);
  assign bvalid    = b_pend;
  assign rvalid    = r_pend;
  assign bresp     = bresp_cfg;
  assign rresp     = rresp_cfg;
  assign rdata     = rdata_cfg;
  assign s_arready = s_arvalid && (s_ar_cnt >= 30);
  assign s_rvalid  = s_r_pend;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; s_ar_cnt <= 0;
      aw_seen <= 1'b0; w_seen <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0; s_r_pend <= 1'b0;
      w_hold <= 1'b0; wdata_prev <= '0;
    end else begin
      if (awvalid && awready) begin aw_cnt <= 0; aw_seen <= 1'b1; end
      else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready) begin w_cnt <= 0; w_seen <= 1'b1; end
      else if (wvalid) w_cnt <= w_cnt + 1;
      if ((aw_seen || (awvalid && awready)) && (w_seen || (wvalid && wready)) && !b_pend) begin
        b_pend <= 1'b1; aw_seen <= 1'b0; w_seen <= 1'b0;
      end
      if (bvalid && bready) begin b_pend <= 1'b0; b_count <= b_count + 1; end
      if (arvalid && arready) begin ar_cnt <= 0; r_pend <= 1'b1; end
      else if (arvalid) ar_cnt <= ar_cnt + 1;
      if (rvalid && rready) r_pend <= 1'b0;
      if (s_arvalid && s_arready) begin s_ar_cnt <= 0; s_r_pend <= 1'b1; end
      else if (s_arvalid) s_ar_cnt <= s_ar_cnt + 1;
      if (s_rvalid && s_rready) s_r_pend <= 1'b0;
      w_hold     <= wvalid && !wready;
      wdata_prev <= wdata;
      if (w_hold && (wdata != wdata_prev)) w_unstable <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a command and return #1 after the accepting edge.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb);
    logic acc;
    acc       = 1'b0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    for (int n = 0; n < 50 && !acc; n++) begin
      acc = cmd_ready;
      tick();
    end
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int n = 0; n < 200 && !rsp_valid; n++) tick();
    if (!rsp_valid) check("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    s_cmd_valid = 1'b0; s_cmd_write = 1'b0; s_cmd_addr = '0; s_cmd_wdata = '0; s_cmd_wstrb = '0;
    s_rsp_ready = 1'b0;
    aw_dly = 0; w_dly = 0; ar_dly = 0;
    bresp_cfg = 2'b00; rresp_cfg = 2'b00; rdata_cfg = '0;
    b_count = 0; w_unstable = 1'b0;

    #12;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_latency", rsp_latency, 0);
    tick();
    reset = 1'b1;
    tick();
    check("idle_cmd_ready", cmd_ready, 1);
    check("awprot_zero", awprot, 0);

    // write, always-ready slave
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    check("wr_awvalid", awvalid, 1);
    check("wr_wvalid", wvalid, 1);
    check("wr_awaddr", awaddr, 32'h10);
    check("wr_wdata", wdata, 32'hDEAD_BEEF);
    check("wr_cmd_ready_busy", cmd_ready, 0);
    wait_rsp();
    check("wr_resp", rsp_resp, 0);
    check("wr_rdata", rsp_rdata, 0);
    check("wr_latency", rsp_latency, 2);
    check("wr_echo", rsp_write, 1);
    consume();

    // read, arready after 3 cycles
    ar_dly = 3; rdata_cfg = 32'h1234_5678;
    issue(1'b0, 32'h24, 32'h0, 4'h0);
    check("rd_arvalid", arvalid, 1);
    check("rd_araddr", araddr, 32'h24);
    wait_rsp();
    check("rd_rdata", rsp_rdata, 32'h1234_5678);
    check("rd_latency", rsp_latency, 5);
    check("rd_echo", rsp_write, 0);
    consume();
    ar_dly = 0;

    // write, wready 4 cycles after awready
    w_dly = 4; b_count = 0; w_unstable = 1'b0;
    issue(1'b1, 32'h30, 32'h0BAD_F00D, 4'h3);
    tick();
    check("aw_first_awvalid", awvalid, 0);
    check("aw_first_wvalid", wvalid, 1);
    check("aw_first_wdata", wdata, 32'h0BAD_F00D);
    wait_rsp();
    check("aw_first_latency", rsp_latency, 6);
    consume();
    tick(); tick();
    check("aw_first_bcount", b_count, 1);
    check("aw_first_wstable", w_unstable, 0);
    w_dly = 0;

    // write, W before AW
    aw_dly = 2;
    issue(1'b1, 32'h34, 32'h5555_AAAA, 4'hC);
    tick();
    check("w_first_awvalid", awvalid, 1);
    check("w_first_wvalid", wvalid, 0);
    wait_rsp();
    check("w_first_latency", rsp_latency, 4);
    consume();
    aw_dly = 0;

    // error response held under backpressure
    bresp_cfg = 2'b10;
    issue(1'b1, 32'h40, 32'h1, 4'h1);
    wait_rsp();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("err_hold_valid", rsp_valid, 1);
      check("err_hold_resp", rsp_resp, 2'b10);
      check("err_hold_latency", rsp_latency, 2);
    end
    consume();
    check("err_released", rsp_valid, 0);
    bresp_cfg = 2'b00;

    // saturation on the LAT_W=4 instance
    s_cmd_valid = 1'b1; s_cmd_write = 1'b0; s_cmd_addr = 32'h20;
    tick();
    s_cmd_valid = 1'b0;
    for (int n = 0; n < 100 && !s_rsp_valid; n++) tick();
    check("sat_valid", s_rsp_valid, 1);
    check("sat_latency", s_rsp_latency, 15);
    check("sat_rdata", s_rsp_rdata, 32'hA5A5_A5A5);
    s_rsp_ready = 1'b1;
    tick();
    s_rsp_ready = 1'b0;

    // reset in the middle of a write
    aw_dly = 10; w_dly = 10;
    issue(1'b1, 32'h50, 32'h7777_7777, 4'hF);
    tick();
    check("mid_awvalid", awvalid, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_awvalid", awvalid, 0);
    check("mid_rst_wvalid", wvalid, 0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    aw_dly = 0; w_dly = 0;
    tick(); tick();
    reset = 1'b1;
    tick();
    check("post_rst_cmd_ready", cmd_ready, 1);
    rdata_cfg = 32'hCAFE_F00D;
    issue(1'b0, 32'h60, 32'h0, 4'h0);
    wait_rsp();
    check("post_rst_rdata", rsp_rdata, 32'hCAFE_F00D);
    check("post_rst_latency", rsp_latency, 2);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dbchecker_ctrl_master.md
Name: dbchecker_ctrl_master

Overview:
- AXI4-Lite initiator that drives the DBChecker s_axil_ctrl register port from a simple command/response interface.
- Used by on-chip firmware-less setup logic and by testbenches to program and read checker control registers.
- Executes one single-beat read or write at a time.
- Reports the AXI response code and the transaction latency for each command.

Parameters:
- ADDR_W, 32, AXI-Lite address width.
- DATA_W, 32, AXI-Lite data width; strobe width is DATA_W/8.
- LAT_W, 16, width of the saturating latency counter.

Ports:
- clock  in  1  single clock; every flop is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  register address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- cmd_wstrb  in  DATA_W/8  write byte strobes; ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  AXI BRESP or RRESP.
- rsp_latency  out  LAT_W  cycles from command accept to the B/R handshake, saturating.
- m_axil_ctrl_awaddr/awprot/awvalid  out  ADDR_W/3/1; m_axil_ctrl_awready  in  1.
- m_axil_ctrl_wdata/wstrb/wvalid  out  DATA_W/DATA_W/8/1; m_axil_ctrl_wready  in  1.
- m_axil_ctrl_bresp  in  2; m_axil_ctrl_bvalid  in  1; m_axil_ctrl_bready  out  1.
- m_axil_ctrl_araddr/arprot/arvalid  out  ADDR_W/3/1; m_axil_ctrl_arready  in  1.
- m_axil_ctrl_rdata/rresp/rvalid  in  DATA_W/2/1; m_axil_ctrl_rready  out  1.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all valid/ready outputs 0; all data/addr/resp/latency outputs 0.
- awprot and arprot are constant 3'b000.
- States: IDLE, WR (AW and W outstanding), WB (await B), RA (await AR), RR (await R), RSP.
- cmd_ready=1 only in IDLE.
  - On accept, addr/data/strb/write are registered.
  - Next cycle the state is WR (write) or RA (read); awvalid+wvalid or arvalid assert that same cycle.
  - Minimum latency: command accept to valid is 1 cycle.
- WR:
  - awvalid and wvalid assert together. Each deasserts independently on its own handshake, tracked by aw_done and w_done flags.
  - AW-before-W, W-before-AW and same-cycle completion are all legal.
  - When both have completed (in the same or different cycles), go to WB.
  - Payload is held stable while valid is high.
- WB: bready=1. On bvalid, capture bresp, set rsp_rdata=0, go to RSP.
- RA: arvalid=1 until arready, then go to RR.
- RR: rready=1. On rvalid, capture rdata and rresp, go to RSP.
- bready/rready are 0 in all other states.
- RSP: rsp_valid=1 and outputs are held stable until rsp_ready. Then go to IDLE, where the next command can be accepted on the following cycle.
- Latency counter:
  - Cleared to 0 on command accept.
  - Increments every cycle in WR/WB/RA/RR and saturates at 2^LAT_W-1.
  - Value including the B/R handshake cycle is latched into rsp_latency.
  - With an always-ready slave: write latency is 2 (WR, WB); read latency is 2 (RA, RR).
- Responses are passed through unmodified; SLVERR/DECERR are not retried.
- Valid signals never drop without a handshake; there is no abort path. Only reset ends a transaction mid-flight.
- Reset asserted mid-transaction: all outputs go to their reset values immediately, and the in-flight command is lost.

Test Plan:
- Write, always-ready slave: cmd addr=0x10, wdata=0xDEADBEEF, wstrb=0xF -> AW/W valid the cycle after accept; rsp_resp=0, rsp_rdata=0, rsp_latency=2.
- Read, slave returns rdata=0x12345678, rresp=0 with arready delayed 3 cycles -> rsp_rdata=0x12345678, rsp_latency=5.
- Write with wready 4 cycles after awready -> awvalid drops after its handshake, wvalid stays high with stable data until wready; exactly one B accepted.
- Slave returns bresp=2'b10 -> rsp_resp=2'b10; rsp_valid held with stable outputs for 3 cycles of rsp_ready=0.
- Saturation with LAT_W=4: arready delayed 30 cycles -> rsp_latency=15.
- Reset pulled low while awvalid is high -> awvalid, wvalid and cmd_ready go 0 asynchronously; after release cmd_ready=1 and a new read completes normally.
